// File: rtl/dispatch_ctrl_if.sv
// Bundle of the decoder, ROB, free-list, RS and stall-counter signals around the dispatch stage.
// The slave modport is the dispatch stage itself; master is its surroundings.
interface dispatch_ctrl_if #(
    parameter int NUM_FU    = 6,
    parameter int PAYLOAD_W = 96,
    parameter int ROB_TAG_W = 5,
    parameter int PREG_W    = 6,
    parameter int CNT_W     = 16
) ();
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [2:0]           in_fu_sel;
    logic [4:0]           in_rd_addr;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 rob_ready;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic                 rob_alloc;
    logic                 rob_exc;
    logic                 fl_empty;
    logic [PREG_W-1:0]    fl_preg;
    logic                 fl_pop;
    logic [NUM_FU-1:0]    rs_ready;
    logic [NUM_FU-1:0]    rs_valid;
    logic [PAYLOAD_W-1:0] rs_payload;
    logic [ROB_TAG_W-1:0] rs_rob_tag;
    logic [PREG_W-1:0]    rs_pd;
    logic                 cnt_clr;
    logic [CNT_W-1:0]     stall_rob_cnt;
    logic [CNT_W-1:0]     stall_fl_cnt;
    logic [CNT_W-1:0]     stall_rs_cnt;

    modport master (
        output flush, in_valid, in_fu_sel, in_rd_addr, in_payload,
        output rob_ready, rob_tag, fl_empty, fl_preg, rs_ready, cnt_clr,
        input  in_ready, rob_alloc, rob_exc, fl_pop, rs_valid, rs_payload,
        input  rs_rob_tag, rs_pd, stall_rob_cnt, stall_fl_cnt, stall_rs_cnt
    );

    modport slave (
        input  flush, in_valid, in_fu_sel, in_rd_addr, in_payload,
        input  rob_ready, rob_tag, fl_empty, fl_preg, rs_ready, cnt_clr,
        output in_ready, rob_alloc, rob_exc, fl_pop, rs_valid, rs_payload,
        output rs_rob_tag, rs_pd, stall_rob_cnt, stall_fl_cnt, stall_rs_cnt
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Single-entry dispatch stage: holds one decoded instruction, allocates ROB entry and
// destination preg, strobes the selected reservation station, and counts stall causes.
module dispatch_ctrl #(
    parameter int NUM_FU    = 6,
    parameter int PAYLOAD_W = 96,
    parameter int ROB_TAG_W = 5,
    parameter int PREG_W    = 6,
    parameter int CNT_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    dispatch_ctrl_if.slave bus
);

    logic                 hold_valid;
    logic [2:0]           hold_sel;
    logic [4:0]           hold_rd;
    logic [PAYLOAD_W-1:0] hold_payload;
    logic [CNT_W-1:0]     stall_rob;
    logic [CNT_W-1:0]     stall_fl;
    logic [CNT_W-1:0]     stall_rs;

    logic                 need_pd;
    logic                 illegal;
    logic [NUM_FU-1:0]    sel_oh;
    logic                 rs_ok;
    logic                 fire;
    logic                 ready;
    logic                 capture;
    logic                 stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign need_pd = (hold_rd != 5'd0);
    assign illegal = (int'(hold_sel) >= NUM_FU);

    // Illegal selects decode to all-zero, which keeps rs_valid one-hot or empty.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            sel_oh[i] = (int'(hold_sel) == i);
        end
    end

    assign rs_ok   = illegal | (|(sel_oh & bus.rs_ready));
    assign fire    = hold_valid & ~bus.flush & bus.rob_ready
                   & (~need_pd | ~bus.fl_empty) & rs_ok;
    assign ready   = ~hold_valid | fire;
    assign capture = bus.in_valid & ready & ~bus.flush;
    assign stall   = hold_valid & ~fire & ~bus.flush;

    assign bus.in_ready   = ready;
    assign bus.rob_alloc  = fire;
    assign bus.rob_exc    = fire & illegal;
    assign bus.fl_pop     = fire & need_pd & ~illegal;
    assign bus.rs_valid   = {NUM_FU{fire}} & sel_oh;
    assign bus.rs_rob_tag = (fire & ~illegal) ? bus.rob_tag : '0;
    assign bus.rs_pd      = (fire & ~illegal & need_pd) ? bus.fl_preg : '0;
    // Payload is gated by hold_valid so the data register itself needs no reset.
    assign bus.rs_payload = hold_valid ? hold_payload : '0;

    assign bus.stall_rob_cnt = stall_rob;
    assign bus.stall_fl_cnt  = stall_fl;
    assign bus.stall_rs_cnt  = stall_rs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
        end else if (bus.flush) begin
            hold_valid <= 1'b0;
        end else if (capture) begin
            hold_valid <= 1'b1;
        end else if (fire) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hold_sel     <= bus.in_fu_sel;
            hold_rd      <= bus.in_rd_addr;
            hold_payload <= bus.in_payload;
        end
    end

    // One counter per stalled cycle, ROB first, then free list, then RS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_rob <= '0;
            stall_fl  <= '0;
            stall_rs  <= '0;
        end else if (bus.cnt_clr) begin
            stall_rob <= '0;
            stall_fl  <= '0;
            stall_rs  <= '0;
        end else if (stall) begin
            if (!bus.rob_ready) begin
                stall_rob <= sat_inc(stall_rob);
            end else if (need_pd && bus.fl_empty) begin
                stall_fl <= sat_inc(stall_fl);
            end else begin
                stall_rs <= sat_inc(stall_rs);
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl: throughput, routing, stall accounting, flush,
// illegal select, counter clear/saturation and asynchronous reset.
module tb_dispatch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    dispatch_ctrl_if #(.CNT_W(16)) m ();
    dispatch_ctrl_if #(.CNT_W(4))  s ();

    dispatch_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m.slave)
    );

    // Narrow-counter copy so the saturation boundary is reached in a few cycles.
    dispatch_ctrl #(.CNT_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s.slave)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] sel, input logic [4:0] rd, input logic [95:0] pl);
        m.in_valid   = 1'b1;
        m.in_fu_sel  = sel;
        m.in_rd_addr = rd;
        m.in_payload = pl;
        step();
        m.in_valid   = 1'b0;
    endtask

    initial begin
        m.flush = 0; m.in_valid = 0; m.in_fu_sel = 0; m.in_rd_addr = 0; m.in_payload = '0;
        m.rob_ready = 1; m.rob_tag = 0; m.fl_empty = 0; m.fl_preg = 6'd12;
        m.rs_ready = 6'h3f; m.cnt_clr = 0;
        s.flush = 0; s.in_valid = 0; s.in_fu_sel = 0; s.in_rd_addr = 0; s.in_payload = '0;
        s.rob_ready = 1; s.rob_tag = 0; s.fl_empty = 0; s.fl_preg = 6'd1;
        s.rs_ready = 6'h00; s.cnt_clr = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", m.in_ready, 1);
        check_val("rst_rob_alloc", m.rob_alloc, 0);
        check_val("rst_rs_valid", m.rs_valid, 0);
        check_val("rst_rs_payload", m.rs_payload, 0);
        check_val("rst_cnt_rs", m.stall_rs_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Back-to-back throughput: 8 arith ops, rd=5, preg 12
        for (int k = 0; k <= 8; k++) begin
            m.in_valid   = (k < 8);
            m.in_fu_sel  = 3'd0;
            m.in_rd_addr = 5'd5;
            m.in_payload = 96'(100 + k);
            m.rob_tag    = 5'(k);
            @(negedge clk);
            check_val("tp_in_ready", m.in_ready, 1);
            if (k == 0) begin
                check_val("tp_first_idle", m.rob_alloc, 0);
            end else begin
                check_val("tp_rob_alloc", m.rob_alloc, 1);
                check_val("tp_fl_pop", m.fl_pop, 1);
                check_val("tp_rs_valid", m.rs_valid, 6'b000001);
                check_val("tp_rs_pd", m.rs_pd, 12);
                check_val("tp_rs_rob_tag", m.rs_rob_tag, k);
                check_val("tp_rs_payload", m.rs_payload, 100 + k - 1);
            end
            step();
        end
        m.in_valid = 1'b0;

        // Store-like op on agen with no destination
        m.rob_tag = 5'd17;
        send(3'd5, 5'd0, 96'hABC);
        @(negedge clk);
        check_val("st_rs_valid", m.rs_valid, 6'b100000);
        check_val("st_fl_pop", m.fl_pop, 0);
        check_val("st_rs_pd", m.rs_pd, 0);
        check_val("st_rob_tag", m.rs_rob_tag, 17);
        check_val("st_payload", m.rs_payload, 96'hABC);
        step();

        // Mult RS full for 4 cycles
        m.rs_ready = 6'b111011;
        send(3'd2, 5'd3, 96'h222);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("rs_stall_in_ready", m.in_ready, 0);
            check_val("rs_stall_rob_alloc", m.rob_alloc, 0);
            step();
        end
        m.rs_ready = 6'h3f;
        @(negedge clk);
        check_val("rs_stall_cnt", m.stall_rs_cnt, 4);
        check_val("rs_stall_rob_cnt", m.stall_rob_cnt, 0);
        check_val("rs_stall_fl_cnt", m.stall_fl_cnt, 0);
        check_val("rs_release_valid", m.rs_valid, 6'b000100);
        check_val("rs_release_fl_pop", m.fl_pop, 1);
        step();

        // ROB not ready and free list empty together: ROB has priority
        m.rob_ready = 0;
        m.fl_empty  = 1;
        send(3'd0, 5'd7, 96'h333);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("rob_stall_alloc", m.rob_alloc, 0);
            check_val("rob_stall_fl_pop", m.fl_pop, 0);
            step();
        end
        m.rob_ready = 1;
        m.fl_empty  = 0;
        @(negedge clk);
        check_val("rob_stall_cnt", m.stall_rob_cnt, 3);
        check_val("rob_stall_fl_cnt", m.stall_fl_cnt, 0);
        check_val("rob_stall_rs_cnt", m.stall_rs_cnt, 4);
        check_val("rob_release_alloc", m.rob_alloc, 1);
        step();

        // Flush while held and stalled
        m.rs_ready = 6'h00;
        send(3'd1, 5'd4, 96'h444);
        @(negedge clk);
        check_val("fl_pre_in_ready", m.in_ready, 0);
        step();
        m.flush    = 1;
        m.rs_ready = 6'h3f;
        @(negedge clk);
        check_val("flush_rob_alloc", m.rob_alloc, 0);
        check_val("flush_fl_pop", m.fl_pop, 0);
        check_val("flush_rs_valid", m.rs_valid, 0);
        step();
        m.flush = 0;
        @(negedge clk);
        check_val("post_flush_in_ready", m.in_ready, 1);
        check_val("post_flush_rob_alloc", m.rob_alloc, 0);
        check_val("post_flush_rs_cnt", m.stall_rs_cnt, 5);
        step();
        @(negedge clk);
        check_val("post_flush_rob_alloc2", m.rob_alloc, 0);
        step();

        // Illegal functional-unit select
        send(3'd7, 5'd9, 96'h777);
        @(negedge clk);
        check_val("ill_rob_alloc", m.rob_alloc, 1);
        check_val("ill_rob_exc", m.rob_exc, 1);
        check_val("ill_rs_valid", m.rs_valid, 0);
        check_val("ill_fl_pop", m.fl_pop, 0);
        step();

        // Counter clear wins over a same-cycle increment
        m.rs_ready = 6'h00;
        send(3'd3, 5'd0, 96'h555);
        @(negedge clk);
        check_val("clr_pre_in_ready", m.in_ready, 0);
        step();
        m.cnt_clr = 1;
        @(negedge clk);
        check_val("clr_pre_rs_cnt", m.stall_rs_cnt, 6);
        step();
        m.cnt_clr = 0;
        @(negedge clk);
        check_val("clr_rs_cnt", m.stall_rs_cnt, 0);
        check_val("clr_rob_cnt", m.stall_rob_cnt, 0);
        step();
        m.rs_ready = 6'h3f;
        @(negedge clk);
        check_val("clr_recount_rs", m.stall_rs_cnt, 1);
        check_val("clr_release_valid", m.rs_valid, 6'b001000);
        step();

        // Saturation on the 4-bit instance: 4'hE is the all-ones-minus-one point
        s.in_valid = 1; s.in_fu_sel = 3'd0; s.in_rd_addr = 5'd0; s.in_payload = 96'h1;
        step();
        s.in_valid = 0;
        repeat (14) step();
        @(negedge clk);
        check_val("sat_near", s.stall_rs_cnt, 4'hE);
        step();
        step();
        step();
        @(negedge clk);
        check_val("sat_hold", s.stall_rs_cnt, 4'hF);
        check_val("sat_rob_cnt", s.stall_rob_cnt, 0);
        step();

        // Asynchronous reset in the middle of a stall
        m.rs_ready = 6'h00;
        send(3'd4, 5'd6, 96'h666);
        @(negedge clk);
        check_val("ar_pre_rs_cnt", m.stall_rs_cnt, 1);
        step();
        check_val("ar_pre_in_ready", m.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check_val("ar_in_ready", m.in_ready, 1);
        check_val("ar_rob_alloc", m.rob_alloc, 0);
        check_val("ar_rs_valid", m.rs_valid, 0);
        check_val("ar_rs_payload", m.rs_payload, 0);
        check_val("ar_rs_cnt", m.stall_rs_cnt, 0);
        check_val("ar_sat_cnt", s.stall_rs_cnt, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Single-entry dispatch stage between the decoder output and the reservation stations (RS).
- Captures one decoded instruction and allocates a ROB entry.
- Pops a physical register from the free list when the instruction writes a non-zero rd.
- Routes the instruction to the RS selected by its functional-unit field.
- Keeps saturating per-cause stall counters for performance analysis.

Parameters:
- NUM_FU, 6, number of RS targets; func_unit_sel encoding: 0 arith, 1 comp, 2 mult, 3 division, 4 branch, 5 agen.
- PAYLOAD_W, 96, opaque decoded-instruction payload width (forwarded unchanged).
- ROB_TAG_W, 5, ROB index width.
- PREG_W, 6, physical register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush (branch mispredict); synchronous.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage can accept this cycle.
- in_fu_sel  in  3  functional-unit select.
- in_rd_addr  in  5  architectural destination; 0 means no writeback.
- in_payload  in  PAYLOAD_W  decoded fields.
- rob_ready  in  1  ROB has a free entry.
- rob_tag  in  ROB_TAG_W  tag the ROB will assign on alloc.
- rob_alloc  out  1  allocate ROB entry this cycle.
- rob_exc  out  1  with rob_alloc: illegal fu_sel, entry completes as exception.
- fl_empty  in  1  free list empty.
- fl_preg  in  PREG_W  head of free list.
- fl_pop  out  1  consume fl_preg.
- rs_ready  in  NUM_FU  per-RS space available.
- rs_valid  out  NUM_FU  one-hot dispatch strobe.
- rs_payload  out  PAYLOAD_W  held payload.
- rs_rob_tag  out  ROB_TAG_W  ROB tag accompanying dispatch.
- rs_pd  out  PREG_W  allocated preg; 0 when rd==0.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_rob_cnt  out  CNT_W  cycles stalled on ROB.
- stall_fl_cnt  out  CNT_W  cycles stalled on free list.
- stall_rs_cnt  out  CNT_W  cycles stalled on RS.

Behaviour:
- State: hold_valid, hold_sel, hold_rd, hold_payload, three counters.
- Reset (rst_n low, async): hold_valid=0, counters=0. Every output is 0, except in_ready=1.
- need_pd = (hold_rd != 0).
- illegal = (hold_sel >= NUM_FU).
- fire = hold_valid & !flush & rob_ready & (!need_pd | !fl_empty) & (illegal | rs_ready[hold_sel]).
- in_ready = !hold_valid | fire. It is combinational and must not depend on in_valid.
- Capture: in_valid & in_ready & !flush loads the hold register, with hold_valid=1 next cycle. Back-to-back fire+capture sustains 1 instruction/cycle.
- On fire, all of the following are asserted the same cycle, combinationally from the hold register:
  - rob_alloc=1.
  - fl_pop=need_pd.
  - If not illegal: rs_valid[hold_sel]=1 with rs_rob_tag=rob_tag and rs_pd=(need_pd ? fl_preg : 0).
  - If illegal: rob_exc=1, rs_valid=0, and fl_pop=0 regardless of rd.
- When not firing: rob_alloc, fl_pop, rob_exc and rs_valid are 0. rs_payload may hold stale data.
- Dispatch latency: 1 cycle minimum (capture at edge N, fire in cycle N+1).
- Flush: hold_valid=0 next edge and no capture that cycle. fire is suppressed in the flush cycle, so no ROB/free-list/RS side effects occur.
- rs_valid is always one-hot or zero, never multi-hot.
- Stall accounting, each cycle with hold_valid & !fire & !flush; exactly one counter increments, by priority:
  1. !rob_ready -> rob counter.
  2. Else need_pd & fl_empty -> fl counter.
  3. Else rs counter.
- Counters saturate at all-ones.
- cnt_clr clears all counters and overrides an increment in the same cycle.
- Inputs are don't-care while in_valid=0. in_payload is captured only on a handshake.

Test Plan:
- Reset, then hold in_valid=1 with fu_sel=0, rd=5; ROB ready, fl_preg=12, all RS ready -> cycle 1: rob_alloc=1, fl_pop=1, rs_valid=6'b000001, rs_pd=12, rs_rob_tag=rob_tag. Throughput 1/cycle over 8 instructions.
- Store-like op, fu_sel=5, rd=0 -> rs_valid=6'b100000, fl_pop=0, rs_pd=0.
- rs_ready[2]=0 for 4 cycles with a mult op held -> in_ready=0 and stall_rs_cnt=4. Dispatch on release; other counters unchanged.
- rob_ready=0 and fl_empty=1 simultaneously for 3 cycles -> stall_rob_cnt +3, stall_fl_cnt +0.
- Flush while held and stalled -> next cycle hold_valid=0 and no rob_alloc ever for that op. fu_sel=7 -> rob_alloc=1, rob_exc=1, rs_valid=0, fl_pop=0.
- Preload counters near saturation, at 16'hFFFE, and stall 3 cycles -> counter stays 16'hFFFF. Assert rst_n low mid-stall -> outputs 0 and in_ready=1 immediately, without waiting for a clock edge.
